// File: rtl/hs32_mem_arbiter.sv
// Fetch/execute memory request arbiter driving a 1-cycle synchronous single-port RAM.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed exec priority.
module hs32_mem_arbiter #(
    parameter int unsigned AW          = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   addr_f,
    input  logic          reqm_f,
    output logic [31:0]   dtr_f,
    output logic          ackm_f,
    input  logic          flush,
    input  logic [31:0]   addr_e,
    input  logic [31:0]   dtw_e,
    input  logic          rw_e,
    input  logic          reqm_e,
    output logic [31:0]   dtr_e,
    output logic          ackm_e,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_dtw,
    output logic          mem_ce,
    output logic          mem_we,
    input  logic [31:0]   mem_dtr
);
    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_E} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic          cancel_q, cancel_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_dtw_q, mem_dtw_d;
    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   dtr_f_q, dtr_f_d;
    logic [31:0]   dtr_e_q, dtr_e_d;
    logic          ackm_f_q, ackm_f_d;
    logic          ackm_e_q, ackm_e_d;
    logic          grant_e;
    logic          fetch_flush;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_f_q, prio_f_d;  // 1: fetch wins the next tie
    assign grant_e = reqm_e && !(reqm_f && prio_f_q);
`else
    assign grant_e = reqm_e;
`endif

    assign fetch_flush = flush && (owner_q == OWN_F);

    generate
        if (AW < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{addr_f[31:AW], addr_e[31:AW]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            cancel_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dtw_q  <= '0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            dtr_f_q    <= '0;
            dtr_e_q    <= '0;
            ackm_f_q   <= 1'b0;
            ackm_e_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_f_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            cancel_q   <= cancel_d;
            mem_addr_q <= mem_addr_d;
            mem_dtw_q  <= mem_dtw_d;
            mem_ce_q   <= mem_ce_d;
            mem_we_q   <= mem_we_d;
            dtr_f_q    <= dtr_f_d;
            dtr_e_q    <= dtr_e_d;
            ackm_f_q   <= ackm_f_d;
            ackm_e_q   <= ackm_e_d;
`ifdef ARB_ROUND_ROBIN_EN
            prio_f_q   <= prio_f_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        cancel_d   = cancel_q;
        mem_addr_d = mem_addr_q;
        mem_dtw_d  = mem_dtw_q;
        mem_ce_d   = mem_ce_q;
        mem_we_d   = mem_we_q;
        dtr_f_d    = dtr_f_q;
        dtr_e_d    = dtr_e_q;
        ackm_f_d   = ackm_f_q;
        ackm_e_d   = ackm_e_q;
`ifdef ARB_ROUND_ROBIN_EN
        prio_f_d   = prio_f_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (reqm_e || reqm_f) begin
                    if (grant_e) begin
                        owner_d    = OWN_E;
                        mem_addr_d = addr_e[AW-1:0];
                        mem_dtw_d  = dtw_e;
                        rw_d       = rw_e;
                    end else begin
                        owner_d    = OWN_F;
                        mem_addr_d = addr_f[AW-1:0];
                        mem_dtw_d  = '0;
                        rw_d       = 1'b0;
                    end
                    mem_ce_d = 1'b1;
                    mem_we_d = grant_e && rw_e;
                    cnt_d    = 4'(WAIT_STATES);
                    cancel_d = 1'b0;
                    state_d  = S_STROBE;
`ifdef ARB_ROUND_ROBIN_EN
                    prio_f_d = grant_e;
`endif
                end
            end
            S_STROBE: begin
                mem_ce_d = 1'b0;
                mem_we_d = 1'b0;
                if (fetch_flush) cancel_d = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (fetch_flush) cancel_d = 1'b1;
                end else begin
                    // A flush seen anywhere in the access suppresses only the fetch response.
                    if (owner_q == OWN_E) begin
                        ackm_e_d = 1'b1;
                        if (!rw_q) dtr_e_d = mem_dtr;
                    end else if (owner_q == OWN_F && !cancel_q && !fetch_flush) begin
                        ackm_f_d = 1'b1;
                        dtr_f_d  = mem_dtr;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ackm_f_d = 1'b0;
                ackm_e_d = 1'b0;
                owner_d  = OWN_NONE;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign mem_dtw  = mem_dtw_q;
    assign mem_ce   = mem_ce_q;
    assign mem_we   = mem_we_q;
    assign dtr_f    = dtr_f_q;
    assign dtr_e    = dtr_e_q;
    assign ackm_f   = ackm_f_q;
    assign ackm_e   = ackm_e_q;
endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Directed bench for hs32_mem_arbiter: one zero-wait and one 3-wait-state instance, each with a RAM model.
module tb_hs32_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] f0_addr, e0_addr, e0_dtw, f0_dtr, e0_dtr, m0_dtw, m0_dtr;
    logic        f0_req, e0_req, e0_rw, flush0, f0_ack, e0_ack, m0_ce, m0_we;
    logic [15:0] m0_addr;
    logic [31:0] mem0 [256];

    logic [31:0] f3_addr, e3_addr, e3_dtw, f3_dtr, e3_dtr, m3_dtw, m3_dtr;
    logic        f3_req, e3_req, e3_rw, flush3, f3_ack, e3_ack, m3_ce, m3_we;
    logic [15:0] m3_addr;
    logic [31:0] mem3 [256];

    hs32_mem_arbiter #(.AW(16), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset_n(reset_n),
        .addr_f(f0_addr), .reqm_f(f0_req), .dtr_f(f0_dtr), .ackm_f(f0_ack), .flush(flush0),
        .addr_e(e0_addr), .dtw_e(e0_dtw), .rw_e(e0_rw), .reqm_e(e0_req), .dtr_e(e0_dtr), .ackm_e(e0_ack),
        .mem_addr(m0_addr), .mem_dtw(m0_dtw), .mem_ce(m0_ce), .mem_we(m0_we), .mem_dtr(m0_dtr)
    );

    hs32_mem_arbiter #(.AW(16), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset_n(reset_n),
        .addr_f(f3_addr), .reqm_f(f3_req), .dtr_f(f3_dtr), .ackm_f(f3_ack), .flush(flush3),
        .addr_e(e3_addr), .dtw_e(e3_dtw), .rw_e(e3_rw), .reqm_e(e3_req), .dtr_e(e3_dtr), .ackm_e(e3_ack),
        .mem_addr(m3_addr), .mem_dtw(m3_dtw), .mem_ce(m3_ce), .mem_we(m3_we), .mem_dtr(m3_dtr)
    );

    // Synchronous RAM: read data appears the cycle after the strobe and holds until the next one.
    always @(posedge clk) begin
        if (m0_ce) begin
            if (m0_we) mem0[m0_addr[7:0]] <= m0_dtw;
            else       m0_dtr <= mem0[m0_addr[7:0]];
        end
        if (m3_ce) begin
            if (m3_we) mem3[m3_addr[7:0]] <= m3_dtw;
            else       m3_dtr <= mem3[m3_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Single access on the zero-wait instance; returns cycles to ack and the acked read data.
    task automatic acc0(input bit ex, input logic [31:0] a, input logic [31:0] d, input bit rw,
                        output int lat, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        if (ex) begin
            e0_addr = a; e0_dtw = d; e0_rw = rw; e0_req = 1'b1;
        end else begin
            f0_addr = a; f0_req = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (ex ? e0_ack : f0_ack) begin
                got = 1'b1;
                rd  = ex ? e0_dtr : f0_dtr;
            end
        end
        e0_req = 1'b0;
        f0_req = 1'b0;
        chk("acc_ack_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [31:0] last_f;
        int          ack_cyc [4];
        int          k;
        int          nack;

        reset_n = 1'b0;
        f0_addr = '0; f0_req = 1'b0; e0_addr = '0; e0_dtw = '0; e0_rw = 1'b0; e0_req = 1'b0; flush0 = 1'b0;
        f3_addr = '0; f3_req = 1'b0; e3_addr = '0; e3_dtw = '0; e3_rw = 1'b0; e3_req = 1'b0; flush3 = 1'b0;
        mem0[5]    <= 32'hDEADBEEF;
        mem0[9]    <= 32'hA5A50009;
        mem0[8'h10] <= 32'h00001010;
        mem0[8'h20] <= 32'h00002020;
        mem0[8'h30] <= 32'h00003030;
        mem0[8'h31] <= 32'h00003131;
        mem0[8'h40] <= 32'h00004040;
        mem0[8'h50] <= 32'h00005050;
        mem0[8'h51] <= 32'h00005151;
        mem0[8'h60] <= 32'h00006060;
        for (int i = 0; i < 4; i++) mem3[i] <= 32'hF00D0000 + 32'(i);
        tick();
        tick();

        chk("rst_ackm_f", {31'b0, f0_ack}, 32'd0);
        chk("rst_ackm_e", {31'b0, e0_ack}, 32'd0);
        chk("rst_mem_ce", {31'b0, m0_ce}, 32'd0);
        chk("rst_mem_we", {31'b0, m0_we}, 32'd0);
        chk("rst_dtr_f", f0_dtr, 32'd0);
        chk("rst_mem_addr", {16'b0, m0_addr}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Fetch read, zero wait states: cycle-exact timing
        f0_addr = 32'd5; f0_req = 1'b1;
        tick();
        chk("t2_ce", {31'b0, m0_ce}, 32'd1);
        chk("t2_addr", {16'b0, m0_addr}, 32'd5);
        chk("t2_we", {31'b0, m0_we}, 32'd0);
        chk("t2_ack_early", {31'b0, f0_ack}, 32'd0);
        tick();
        chk("t2_ce_drop", {31'b0, m0_ce}, 32'd0);
        chk("t2_ack_wait", {31'b0, f0_ack}, 32'd0);
        tick();
        chk("t2_ack", {31'b0, f0_ack}, 32'd1);
        chk("t2_dtr_f", f0_dtr, 32'hDEADBEEF);
        chk("t2_ack_e_quiet", {31'b0, e0_ack}, 32'd0);
        f0_req = 1'b0;
        tick();
        chk("t2_ack_pulse", {31'b0, f0_ack}, 32'd0);

        // Exec read, exec write, then fetch of the written word
        acc0(1'b1, 32'd9, 32'd0, 1'b0, lat, rd);
        chk("t3_rd_lat", 32'(lat), 32'd3);
        chk("t3_rd_dtr_e", rd, 32'hA5A50009);
        acc0(1'b1, 32'd7, 32'h12345678, 1'b1, lat, rd);
        chk("t3_wr_lat", 32'(lat), 32'd3);
        chk("t3_wr_dtr_e_held", rd, 32'hA5A50009);
        acc0(1'b0, 32'h00FF0007, 32'd0, 1'b0, lat, rd);
        chk("t3_fetch_back", rd, 32'h12345678);

        // Tie: exec first, fetch 4 cycles later
        e0_addr = 32'h10; e0_rw = 1'b0; e0_req = 1'b1;
        f0_addr = 32'h20; f0_req = 1'b1;
        tick();
        chk("t4_first_addr", {16'b0, m0_addr}, 32'h10);
        tick();
        tick();
        chk("t4_ack_e", {31'b0, e0_ack}, 32'd1);
        chk("t4_ack_f_excl", {31'b0, f0_ack}, 32'd0);
        chk("t4_dtr_e", e0_dtr, 32'h00001010);
        e0_req = 1'b0;
        tick();
        tick();
        chk("t4_second_addr", {16'b0, m0_addr}, 32'h20);
        tick();
        tick();
        chk("t4_ack_f", {31'b0, f0_ack}, 32'd1);
        chk("t4_ack_e_excl", {31'b0, e0_ack}, 32'd0);
        chk("t4_dtr_f", f0_dtr, 32'h00002020);
        f0_req = 1'b0;
        tick();

        // Two consecutive ties: exec re-requests straight after its ack
        e0_addr = 32'h30; e0_req = 1'b1;
        f0_addr = 32'h40; f0_req = 1'b1;
        tick();
        tick();
        tick();
        chk("t4b_ack_e", {31'b0, e0_ack}, 32'd1);
        chk("t4b_dtr_e", e0_dtr, 32'h00003030);
        e0_addr = 32'h31;
        tick();
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        chk("t4b_tie2_addr", {16'b0, m0_addr}, 32'h40);
        tick();
        tick();
        chk("t4b_tie2_ack_f", {31'b0, f0_ack}, 32'd1);
        chk("t4b_tie2_dtr_f", f0_dtr, 32'h00004040);
        last_f = 32'h00004040;
`else
        chk("t4b_tie2_addr", {16'b0, m0_addr}, 32'h31);
        tick();
        tick();
        chk("t4b_tie2_ack_e", {31'b0, e0_ack}, 32'd1);
        chk("t4b_tie2_dtr_e", e0_dtr, 32'h00003131);
        chk("t4b_tie2_no_f", {31'b0, f0_ack}, 32'd0);
        last_f = 32'h00002020;
`endif
        e0_req = 1'b0;
        f0_req = 1'b0;
        tick();
        tick();

        // Flush during the WAIT of a fetch
        f0_addr = 32'h50; f0_req = 1'b1;
        tick();
        tick();
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        chk("t5_no_ack", {31'b0, f0_ack}, 32'd0);
        chk("t5_dtr_f_held", f0_dtr, last_f);
        f0_addr = 32'h51;
        tick();
        chk("t5_resp_no_ack", {31'b0, f0_ack}, 32'd0);
        tick();
        chk("t5_regrant_ce", {31'b0, m0_ce}, 32'd1);
        chk("t5_regrant_addr", {16'b0, m0_addr}, 32'h51);
        tick();
        tick();
        chk("t5_ack_after", {31'b0, f0_ack}, 32'd1);
        chk("t5_dtr_after", f0_dtr, 32'h00005151);
        f0_req = 1'b0;
        tick();

        // Flush never affects exec
        flush0 = 1'b1;
        acc0(1'b1, 32'h60, 32'd0, 1'b0, lat, rd);
        flush0 = 1'b0;
        chk("t5_exec_flush_lat", 32'(lat), 32'd3);
        chk("t5_exec_flush_dtr", rd, 32'h00006060);

        // WAIT_STATES=3: back-to-back fetches 0..3
        k = 0;
        f3_addr = 32'd0; f3_req = 1'b1;
        for (int c = 1; c <= 60 && k < 4; c++) begin
            tick();
            if (f3_ack) begin
                ack_cyc[k] = c;
                chk("t6_data", f3_dtr, 32'hF00D0000 + 32'(k));
                k++;
                if (k == 4) f3_req = 1'b0;
                else        f3_addr = 32'(k);
            end
        end
        f3_req = 1'b0;
        chk("t6_ack_count", 32'(k), 32'd4);
        if (k == 4) begin
            chk("t6_first_lat", 32'(ack_cyc[0]), 32'd6);
            for (int i = 1; i < 4; i++) chk("t6_interval", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd7);
        end
        tick();
        tick();

        // Reset in the middle of a 3-wait-state fetch
        f3_addr = 32'd2; f3_req = 1'b1;
        tick();
        chk("t1_ce_before", {31'b0, m3_ce}, 32'd1);
        chk("t1_addr_before", {16'b0, m3_addr}, 32'd2);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("t1_ackm_f", {31'b0, f3_ack}, 32'd0);
        chk("t1_ackm_e", {31'b0, e3_ack}, 32'd0);
        chk("t1_mem_ce", {31'b0, m3_ce}, 32'd0);
        chk("t1_mem_we", {31'b0, m3_we}, 32'd0);
        chk("t1_mem_addr", {16'b0, m3_addr}, 32'd0);
        chk("t1_mem_dtw", m3_dtw, 32'd0);
        chk("t1_dtr_f", f3_dtr, 32'd0);
        chk("t1_dtr_e", e3_dtr, 32'd0);
        f3_req = 1'b0;
        tick();
        reset_n = 1'b1;
        nack = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (f3_ack || e3_ack) nack++;
        end
        chk("t1_no_ack_after", 32'(nack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
